// File: rtl/gpmc_sync_regfile.sv
// GPMC slave register file: oversamples the asynchronous GPMC strobes into the fabric clock,
// decodes address/write/read phases and exposes NUM_REGS RW/RO registers to fabric logic.
module gpmc_sync_regfile #(
    parameter int                      DATA_WIDTH  = 16,
    parameter int                      ADDR_WIDTH  = 4,
    parameter int                      NUM_REGS    = 16,
    parameter logic [2**ADDR_WIDTH-1:0] RO_MASK    = {(2**ADDR_WIDTH){1'b0}},
    parameter int                      SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           gpmc_csn,
    input  logic                           gpmc_advn,
    input  logic                           gpmc_wein,
    input  logic                           gpmc_oen,
    input  logic [DATA_WIDTH-1:0]          ad_in,
    output logic [DATA_WIDTH-1:0]          ad_out,
    output logic                           ad_oe,
    input  logic                           fab_we,
    input  logic [ADDR_WIDTH-1:0]          fab_addr,
    input  logic [DATA_WIDTH-1:0]          fab_wdata,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse,
    output logic                           bad_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];

    // Stage 0 is the pin sample, stage SYNC_STAGES-1 the oldest (fully synchronised) one.
    logic [SYNC_STAGES-1:0]  csn_sync_r;
    logic [SYNC_STAGES-1:0]  advn_sync_r;
    logic [SYNC_STAGES-1:0]  wein_sync_r;
    logic [SYNC_STAGES-1:0]  oen_sync_r;
    logic [DATA_WIDTH-1:0]   ad_sync_r [SYNC_STAGES];

    logic                    csn_s;
    logic                    advn_s;
    logic                    wein_s;
    logic                    oen_s;
    logic [DATA_WIDTH-1:0]   ad_s;
    logic                    adv_rise_s;
    logic                    we_rise_s;
    logic                    oe_fall_s;
    logic                    wr_go_s;
    logic                    rd_go_s;
    logic                    addr_hit_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;
    logic [NUM_REGS-1:0]     wr_hot_s;
    logic [NUM_REGS-1:0]     rd_hot_s;

    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
        return ({{(32-ADDR_WIDTH){1'b0}}, a} < 32'(NUM_REGS));
    endfunction

    // Strobe and AD synchronisers; strobes preset inactive so reset release sees no edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csn_sync_r  <= {SYNC_STAGES{1'b1}};
            advn_sync_r <= {SYNC_STAGES{1'b1}};
            wein_sync_r <= {SYNC_STAGES{1'b1}};
            oen_sync_r  <= {SYNC_STAGES{1'b1}};
            for (int k = 0; k < SYNC_STAGES; k++) begin
                ad_sync_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            csn_sync_r   <= {csn_sync_r[SYNC_STAGES-2:0], gpmc_csn};
            advn_sync_r  <= {advn_sync_r[SYNC_STAGES-2:0], gpmc_advn};
            wein_sync_r  <= {wein_sync_r[SYNC_STAGES-2:0], gpmc_wein};
            oen_sync_r   <= {oen_sync_r[SYNC_STAGES-2:0], gpmc_oen};
            ad_sync_r[0] <= ad_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                ad_sync_r[k] <= ad_sync_r[k-1];
            end
        end
    end

    assign csn_s  = csn_sync_r[SYNC_STAGES-1];
    assign advn_s = advn_sync_r[SYNC_STAGES-1];
    assign wein_s = wein_sync_r[SYNC_STAGES-1];
    assign oen_s  = oen_sync_r[SYNC_STAGES-1];
    assign ad_s   = ad_sync_r[SYNC_STAGES-1];

    // ad_s stays aligned with the pre-edge strobe level, i.e. the last sample while the strobe was asserted.
    assign adv_rise_s = advn_sync_r[SYNC_STAGES-2] & ~advn_sync_r[SYNC_STAGES-1];
    assign we_rise_s  = wein_sync_r[SYNC_STAGES-2] & ~wein_sync_r[SYNC_STAGES-1];
    assign oe_fall_s  = ~oen_sync_r[SYNC_STAGES-2] & oen_sync_r[SYNC_STAGES-1];

    // A WEn rise in DATA commits even when CSn rises in the same cycle.
    assign wr_go_s    = (state_r == DATA) & we_rise_s;
    assign rd_go_s    = (state_r == DATA) & ~csn_s & oe_fall_s;
    assign addr_hit_s = is_mapped(addr_r);

    // Address decode: one-hot pulses and the read-data mux (unmapped reads give zero).
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        wr_hot_s  = {NUM_REGS{1'b0}};
        rd_hot_s  = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hot_s[i] = wr_go_s & ~RO_MASK[i] & (addr_r == ADDR_WIDTH'(i));
            rd_hot_s[i] = rd_go_s & (addr_r == ADDR_WIDTH'(i));
            rd_data_s   = rd_data_s | ({DATA_WIDTH{addr_r == ADDR_WIDTH'(i)}} &
                          (RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i]));
        end
    end

    // Register storage; a GPMC commit outranks a fabric write to the same register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (RO_MASK[i]) begin
                    regs_r[i] <= {DATA_WIDTH{1'b0}};
                end else if (wr_hot_s[i]) begin
                    regs_r[i] <= ad_s;
                end else if (fab_we && (fab_addr == ADDR_WIDTH'(i))) begin
                    regs_r[i] <= fab_wdata;
                end
            end
        end
    end

    // Bus-phase FSM with registered read data, output enable, pulses and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            addr_r   <= {ADDR_WIDTH{1'b0}};
            ad_out   <= {DATA_WIDTH{1'b0}};
            ad_oe    <= 1'b0;
            wr_pulse <= {NUM_REGS{1'b0}};
            rd_pulse <= {NUM_REGS{1'b0}};
            bad_addr <= 1'b0;
        end else begin
            wr_pulse <= wr_hot_s;
            rd_pulse <= rd_hot_s;
            ad_oe    <= (state_r == DATA) & ~csn_s & ~oen_s & wein_s & advn_s;
            if (rd_go_s) begin
                ad_out <= rd_data_s;
            end
            if ((wr_go_s | rd_go_s) & ~addr_hit_s) begin
                bad_addr <= 1'b1;
            end else if (wr_go_s & (addr_r == {ADDR_WIDTH{1'b0}})) begin
                bad_addr <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (!csn_s && !advn_s) begin
                        state_r <= ADDR;
                    end
                end
                ADDR: begin
                    if (csn_s) begin
                        state_r <= IDLE;
                    end else if (adv_rise_s) begin
                        addr_r  <= ad_s[ADDR_WIDTH-1:0];
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (csn_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_regq
            assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
        end
    endgenerate

endmodule

// File: tb/tb_gpmc_sync_regfile.sv
// Bench for gpmc_sync_regfile: 12 registers (reg 11 read-only, 12..15 unmapped), host-side GPMC
// transactions driven on pins, checked against an array-based model of the register map.
module tb_gpmc_sync_regfile;
    localparam int          DW     = 16;
    localparam int          AW     = 4;
    localparam int          NR     = 12;
    localparam logic [15:0] RO     = 16'h0800;
    localparam int          RD_LEN = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            gpmc_csn, gpmc_advn, gpmc_wein, gpmc_oen;
    logic [DW-1:0]   ad_in;
    logic [DW-1:0]   ad_out;
    logic            ad_oe;
    logic            fab_we;
    logic [AW-1:0]   fab_addr;
    logic [DW-1:0]   fab_wdata;
    logic [NR*DW-1:0] status_in;
    logic [NR*DW-1:0] reg_q;
    logic [NR-1:0]   wr_pulse, rd_pulse;
    logic            bad_addr;

    gpmc_sync_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gpmc_csn(gpmc_csn), .gpmc_advn(gpmc_advn),
        .gpmc_wein(gpmc_wein), .gpmc_oen(gpmc_oen), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .fab_we(fab_we), .fab_addr(fab_addr), .fab_wdata(fab_wdata),
        .status_in(status_in), .reg_q(reg_q), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse),
        .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Pulse and output-enable activity, accumulated since time zero.
    int          wr_cyc = 0, rd_cyc = 0, oe_cyc = 0;
    logic [NR-1:0] wr_last = '0, rd_last = '0;
    always @(negedge clk) begin
        if (wr_pulse != '0) begin wr_cyc <= wr_cyc + 1; wr_last <= wr_pulse; end
        if (rd_pulse != '0) begin rd_cyc <= rd_cyc + 1; rd_last <= rd_pulse; end
        if (ad_oe) oe_cyc <= oe_cyc + 1;
    end

    // Reference model: register map semantics only.
    logic [15:0] m_regs [NR];
    bit          m_bad;

    function automatic void model_access(input bit wr, input logic [3:0] a, input logic [15:0] d,
                                         output logic [11:0] pulse, output logic [15:0] rdata);
        pulse = '0;
        rdata = '0;
        if (int'(a) >= NR) begin
            m_bad = 1'b1;
        end else if (wr) begin
            if (!RO[a]) begin
                m_regs[a] = d;
                pulse = 12'd1 << a;
            end
            if (a == 4'd0) m_bad = 1'b0;
        end else begin
            pulse = 12'd1 << a;
            rdata = RO[a] ? status_in[int'(a)*16 +: 16] : m_regs[a];
        end
    endfunction

    function automatic void model_fab(input logic [3:0] a, input logic [15:0] d);
        if (int'(a) < NR && !RO[a]) m_regs[a] = d;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 16'h0000;
        m_bad = 1'b0;
    endfunction

    function automatic logic [NR*DW-1:0] model_pack();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*16 +: 16] = m_regs[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic gpmc_write(input logic [3:0] a, input logic [15:0] d, input bit abort, input bit collide);
        logic [15:0] r;
        r = 16'($urandom);
        gpmc_csn = 1'b0; gpmc_advn = 1'b0; ad_in = {r[15:4], a}; tick(5);
        gpmc_advn = 1'b1; tick(5);
        ad_in = d; gpmc_wein = 1'b0; tick(5);
        if (abort) begin
            gpmc_csn = 1'b1; tick(4);
            gpmc_wein = 1'b1; tick(6);
        end else begin
            gpmc_wein = 1'b1; tick(1);
            if (collide) begin fab_we = 1'b1; fab_addr = a; fab_wdata = ~d; end
            tick(1);
            fab_we = 1'b0; tick(3);
            gpmc_csn = 1'b1;
        end
        ad_in = 16'($urandom); tick(6);
    endtask

    task automatic gpmc_read(input logic [3:0] a, output logic [15:0] got, output logic got_oe);
        logic [15:0] r;
        r = 16'($urandom);
        gpmc_csn = 1'b0; gpmc_advn = 1'b0; ad_in = {r[15:4], a}; tick(5);
        gpmc_advn = 1'b1; tick(5);
        ad_in = 16'($urandom); gpmc_oen = 1'b0; tick(RD_LEN);
        got = ad_out; got_oe = ad_oe;
        gpmc_oen = 1'b1; tick(5);
        gpmc_csn = 1'b1; tick(6);
    endtask

    task automatic run_op(input string tag, input bit wr, input logic [3:0] a, input logic [15:0] d,
                          input logic [11:0] exp_pulse, input logic [15:0] exp_rd, input bit exp_bad);
        int wc0, rc0, oc0;
        logic [15:0] got;
        logic got_oe;
        wc0 = wr_cyc; rc0 = rd_cyc; oc0 = oe_cyc;
        if (wr) begin
            gpmc_write(a, d, 1'b0, 1'b0);
            check({tag, " wr_cnt"}, wr_cyc - wc0, (exp_pulse != '0) ? 1 : 0);
            if (exp_pulse != '0) check({tag, " wr_pulse"}, wr_last, exp_pulse);
            check({tag, " oe_cnt"}, oe_cyc - oc0, 0);
        end else begin
            gpmc_read(a, got, got_oe);
            check({tag, " ad_out"}, got, exp_rd);
            check({tag, " ad_oe"}, got_oe, 1'b1);
            check({tag, " oe_cnt"}, oe_cyc - oc0, RD_LEN);
            check({tag, " rd_cnt"}, rd_cyc - rc0, (exp_pulse != '0) ? 1 : 0);
            if (exp_pulse != '0) check({tag, " rd_pulse"}, rd_last, exp_pulse);
            check({tag, " wr_cnt"}, wr_cyc - wc0, 0);
        end
        check({tag, " bad_addr"}, bad_addr, exp_bad);
        check({tag, " reg_q"}, reg_q, model_pack());
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [11:0] exp_pulse;
        logic [15:0] exp_rd;
        bit          exp_bad;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [13];
        logic [11:0] mp;
        logic [15:0] mr;
        int          wc0;
        logic [15:0] d1, d2;

        vecs[0]  = '{1'b1, 4'd2,  16'h1234, 12'h004, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 4'd2,  16'h0000, 12'h004, 16'h1234, 1'b0};
        vecs[2]  = '{1'b1, 4'd11, 16'h0000, 12'h000, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 4'd11, 16'h0000, 12'h800, 16'hBEEF, 1'b0};
        vecs[4]  = '{1'b1, 4'd12, 16'hA5A5, 12'h000, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 4'd12, 16'h0000, 12'h000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b0, 4'd2,  16'h0000, 12'h004, 16'h1234, 1'b1};
        vecs[7]  = '{1'b1, 4'd0,  16'h5555, 12'h001, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 4'd0,  16'h0000, 12'h001, 16'h5555, 1'b0};
        vecs[9]  = '{1'b1, 4'd15, 16'hFFFF, 12'h000, 16'h0000, 1'b1};
        vecs[10] = '{1'b1, 4'd5,  16'h00FF, 12'h020, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 4'd5,  16'h0000, 12'h020, 16'h00FF, 1'b1};
        vecs[12] = '{1'b1, 4'd0,  16'h0000, 12'h001, 16'h0000, 1'b0};

        for (int i = 0; i < NR; i++) status_in[i*16 +: 16] = 16'($urandom);
        status_in[11*16 +: 16] = 16'hBEEF;
        fab_we = 1'b0; fab_addr = '0; fab_wdata = '0; ad_in = '0;

        // Reset held 3 clocks with strobes toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gpmc_csn = 1'($urandom); gpmc_advn = 1'($urandom);
            gpmc_wein = 1'($urandom); gpmc_oen = 1'($urandom);
            tick(1);
        end
        check("reset reg_q", reg_q, '0);
        check("reset ad_oe", ad_oe, 1'b0);
        check("reset bad_addr", bad_addr, 1'b0);
        check("reset wr_pulse", wr_pulse, '0);
        check("reset rd_pulse", rd_pulse, '0);
        check("reset ad_out", ad_out, '0);
        gpmc_csn = 1'b1; gpmc_advn = 1'b1; gpmc_wein = 1'b1; gpmc_oen = 1'b1;
        rst_n = 1'b1;
        model_reset();
        tick(4);

        for (int i = 0; i < 13; i++) begin
            model_access(vecs[i].wr, vecs[i].addr, vecs[i].data, mp, mr);
            run_op($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
                   vecs[i].exp_pulse, vecs[i].exp_rd, vecs[i].exp_bad);
        end

        // CSn rises before WEn rises: transfer abandoned.
        wc0 = wr_cyc;
        gpmc_write(4'd3, 16'hDEAD, 1'b1, 1'b0);
        check("abort wr_cnt", wr_cyc - wc0, 0);
        check("abort reg_q", reg_q, model_pack());

        // Fabric write landing in the same clock as a GPMC commit to reg 1.
        wc0 = wr_cyc;
        gpmc_write(4'd1, 16'hC0DE, 1'b0, 1'b1);
        model_access(1'b1, 4'd1, 16'hC0DE, mp, mr);
        check("collide reg1", reg_q[1*16 +: 16], 16'hC0DE);
        check("collide wr_cnt", wr_cyc - wc0, 1);

        // Fabric-only writes: RW register updates, RO register does not.
        fab_we = 1'b1; fab_addr = 4'd3; fab_wdata = 16'h3C3C; tick(1);
        fab_addr = 4'd11; fab_wdata = 16'h7777; tick(1);
        fab_we = 1'b0; tick(1);
        model_fab(4'd3, 16'h3C3C); model_fab(4'd11, 16'h7777);
        check("fab reg_q", reg_q, model_pack());

        // Two data phases under one CS reuse the latched address.
        d1 = 16'h1111; d2 = 16'h2222; wc0 = wr_cyc;
        gpmc_csn = 1'b0; gpmc_advn = 1'b0; ad_in = 16'hFFF4; tick(5);
        gpmc_advn = 1'b1; tick(5);
        ad_in = d1; gpmc_wein = 1'b0; tick(5); gpmc_wein = 1'b1; tick(5);
        ad_in = d2; gpmc_wein = 1'b0; tick(5); gpmc_wein = 1'b1; tick(5);
        gpmc_csn = 1'b1; tick(6);
        model_access(1'b1, 4'd4, d1, mp, mr);
        model_access(1'b1, 4'd4, d2, mp, mr);
        check("burst wr_cnt", wr_cyc - wc0, 2);
        check("burst reg_q", reg_q, model_pack());

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [3:0]  a;
            logic [15:0] d;
            op = $urandom_range(2, 0);
            a  = 4'($urandom_range(15, 0));
            d  = 16'($urandom);
            if (op == 2) begin
                fab_we = 1'b1; fab_addr = a; fab_wdata = d; tick(1);
                fab_we = 1'b0; tick(1);
                model_fab(a, d);
                check($sformatf("rnd%0d fab reg_q", i), reg_q, model_pack());
            end else begin
                model_access(op == 0, a, d, mp, mr);
                run_op($sformatf("rnd%0d", i), op == 0, a, d, mp, mr, m_bad);
            end
        end

        // Reset in the middle of a write data phase: nothing is committed.
        wc0 = wr_cyc;
        gpmc_csn = 1'b0; gpmc_advn = 1'b0; ad_in = 16'h0006; tick(5);
        gpmc_advn = 1'b1; tick(5);
        ad_in = 16'h9999; gpmc_wein = 1'b0; tick(3);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gpmc_advn = 1'($urandom); gpmc_oen = 1'($urandom); tick(1);
        end
        check("midrst reg_q", reg_q, '0);
        check("midrst bad_addr", bad_addr, 1'b0);
        gpmc_advn = 1'b1; gpmc_oen = 1'b1; rst_n = 1'b1;
        model_reset();
        tick(4);
        gpmc_wein = 1'b1; tick(5);
        gpmc_csn = 1'b1; tick(6);
        check("midrst wr_cnt", wr_cyc - wc0, 0);
        check("midrst reg_q after", reg_q, model_pack());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
